// File: rtl/edge_detect_array.sv
// Multi-channel input conditioner: per channel a synchroniser, a debounce filter
// and a mode-selectable edge detector with a one-cycle pulse and a sticky flag.
module edge_detect_array #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CHANNELS-1:0]   x,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   sticky,
  output logic                  any_event
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_sticky;
    logic                   w_s;
    logic                   w_differ;
    logic                   w_toggle;
    logic                   w_event;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_differ = w_s ^ r_level;
    assign w_toggle = w_differ && (r_cnt == LP_CNT_LAST);
    // Mode bit 0 enables rising edges, bit 1 falling; the new level is ~r_level.
    assign w_event  = w_toggle && en &&
                      (r_level ? mode[2*gi+1] : mode[2*gi]);

    // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
    // aborts a debounce in progress without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync   <= '0;
        r_cnt    <= '0;
        r_level  <= 1'b0;
        r_pulse  <= 1'b0;
        r_sticky <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments make every register here sample the
        // pre-edge values, which is what keeps the shift chain a true chain.
        r_sync <= {r_sync[SYNC_STAGES-2:0], x[gi]};
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (w_toggle) begin
          r_cnt   <= '0;
          r_level <= ~r_level;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        r_pulse  <= w_event;
        // Set wins over clear so an event landing on a clear is never lost.
        r_sticky <= w_event | (r_sticky & ~clr[gi]);
      end
    end

    assign pulse[gi]  = r_pulse;
    assign level[gi]  = r_level;
    assign sticky[gi] = r_sticky;
  end

  assign any_event = |sticky;

endmodule
